// File: rtl/pipe_mem_stage.sv
// MEM stage of a 5-stage MIPS pipeline: EX/MEM and MEM/WB pipeline
// registers around a word-addressed data memory, with lw->sw store-data
// forwarding selected by the external memory forwarding unit.
module pipe_mem_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  ex_opcode,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_write_reg,
  input  logic        ex_regwrite,
  input  logic        stall,
  input  logic        flush,
  input  logic        forwardM,
  output logic [4:0]  exmem_rt,
  output logic [5:0]  exmem_opcode,
  output logic [4:0]  memwb_rt,
  output logic [5:0]  memwb_opcode,
  output logic [4:0]  memwb_write_reg,
  output logic        memwb_regwrite,
  output logic [31:0] memwb_wb_data,
  output logic        misaligned
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  // EX/MEM pipeline register
  logic [5:0]  exmem_opcode_q,    exmem_opcode_d;
  logic [31:0] exmem_alu_q,       exmem_alu_d;
  logic [31:0] exmem_rt_data_q,   exmem_rt_data_d;
  logic [4:0]  exmem_rt_q,        exmem_rt_d;
  logic [4:0]  exmem_write_reg_q, exmem_write_reg_d;
  logic        exmem_regwrite_q,  exmem_regwrite_d;

  // MEM/WB pipeline register
  logic [5:0]  memwb_opcode_q,    memwb_opcode_d;
  logic [4:0]  memwb_rt_q,        memwb_rt_d;
  logic [4:0]  memwb_write_reg_q, memwb_write_reg_d;
  logic        memwb_regwrite_q,  memwb_regwrite_d;
  logic [31:0] memwb_wb_data_q,   memwb_wb_data_d;

  // Data memory; contents are deliberately left unreset
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   mem_rdata;
  logic [31:0]   store_data;
  logic          is_lw;
  logic          is_sw;
  logic          mem_we;

  // Word index, memory read port, store-data forwarding and write enable
  always_comb begin
    idx        = exmem_alu_q[AW+1:2];
    mem_rdata  = mem[idx];
    is_lw      = (exmem_opcode_q == OP_LW);
    is_sw      = (exmem_opcode_q == OP_SW);
    // A store directly behind a load of its rt takes the freshly loaded value
    store_data = forwardM ? memwb_wb_data_q : exmem_rt_data_q;
    // rst_n gating keeps an in-flight store from landing while reset is held
    mem_we     = is_sw && !stall && rst_n;
    misaligned = (is_lw || is_sw) && (exmem_alu_q[1:0] != 2'b00);
  end

  // Next-state for EX/MEM: stall holds, flush inserts a bubble, else capture EX
  always_comb begin
    exmem_opcode_d    = exmem_opcode_q;
    exmem_alu_d       = exmem_alu_q;
    exmem_rt_data_d   = exmem_rt_data_q;
    exmem_rt_d        = exmem_rt_q;
    exmem_write_reg_d = exmem_write_reg_q;
    exmem_regwrite_d  = exmem_regwrite_q;
    if (!stall) begin
      if (flush) begin
        exmem_opcode_d    = 6'd0;
        exmem_alu_d       = 32'd0;
        exmem_rt_data_d   = 32'd0;
        exmem_rt_d        = 5'd0;
        exmem_write_reg_d = 5'd0;
        exmem_regwrite_d  = 1'b0;
      end else begin
        exmem_opcode_d    = ex_opcode;
        exmem_alu_d       = ex_alu_result;
        exmem_rt_data_d   = ex_rt_data;
        exmem_rt_d        = ex_rt;
        exmem_write_reg_d = ex_write_reg;
        exmem_regwrite_d  = ex_regwrite;
      end
    end
  end

  // Next-state for MEM/WB: stall holds, else advance EX/MEM with load or ALU data
  always_comb begin
    memwb_opcode_d    = memwb_opcode_q;
    memwb_rt_d        = memwb_rt_q;
    memwb_write_reg_d = memwb_write_reg_q;
    memwb_regwrite_d  = memwb_regwrite_q;
    memwb_wb_data_d   = memwb_wb_data_q;
    if (!stall) begin
      memwb_opcode_d    = exmem_opcode_q;
      memwb_rt_d        = exmem_rt_q;
      memwb_write_reg_d = exmem_write_reg_q;
      memwb_regwrite_d  = exmem_regwrite_q;
      memwb_wb_data_d   = is_lw ? mem_rdata : exmem_alu_q;
    end
  end

  // Pipeline register flops; reset loads bubbles into both stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_opcode_q    <= 6'd0;
      exmem_alu_q       <= 32'd0;
      exmem_rt_data_q   <= 32'd0;
      exmem_rt_q        <= 5'd0;
      exmem_write_reg_q <= 5'd0;
      exmem_regwrite_q  <= 1'b0;
      memwb_opcode_q    <= 6'd0;
      memwb_rt_q        <= 5'd0;
      memwb_write_reg_q <= 5'd0;
      memwb_regwrite_q  <= 1'b0;
      memwb_wb_data_q   <= 32'd0;
    end else begin
      exmem_opcode_q    <= exmem_opcode_d;
      exmem_alu_q       <= exmem_alu_d;
      exmem_rt_data_q   <= exmem_rt_data_d;
      exmem_rt_q        <= exmem_rt_d;
      exmem_write_reg_q <= exmem_write_reg_d;
      exmem_regwrite_q  <= exmem_regwrite_d;
      memwb_opcode_q    <= memwb_opcode_d;
      memwb_rt_q        <= memwb_rt_d;
      memwb_write_reg_q <= memwb_write_reg_d;
      memwb_regwrite_q  <= memwb_regwrite_d;
      memwb_wb_data_q   <= memwb_wb_data_d;
    end
  end

  // Synchronous store into data memory
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= store_data;
    end
  end

  assign exmem_rt        = exmem_rt_q;
  assign exmem_opcode    = exmem_opcode_q;
  assign memwb_rt        = memwb_rt_q;
  assign memwb_opcode    = memwb_opcode_q;
  assign memwb_write_reg = memwb_write_reg_q;
  assign memwb_regwrite  = memwb_regwrite_q;
  assign memwb_wb_data   = memwb_wb_data_q;

endmodule
